// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   ctrl_state_e : sequencer states (RUN, MC_BUSY, MC_DONE_WAIT)
//   NOP_INSN     : canonical RV32 NOP (addi x0,x0,0) loaded on IF/ID flush
//   REG_X0       : register index of the hard-wired zero register
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN          = 2'd0,
        MC_BUSY      = 2'd1,
        MC_DONE_WAIT = 2'd2
    } ctrl_state_e;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [4:0]  REG_X0   = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard compare between the instruction in
// ID and a load sitting in EX.
// Ports:
//   i_id_rs1_addr / i_id_rs2_addr : source registers of the ID instruction
//   i_id_uses_rs1 / i_id_uses_rs2 : ID instruction actually reads rs1 / rs2
//   i_ex_valid                    : EX holds a valid instruction
//   i_ex_rd_addr                  : destination register of the EX instruction
//   i_ex_mem_read                 : EX instruction is a load
//   o_load_use                    : ID must wait one cycle for the load data
// ---------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs1_addr,
    input  logic [4:0] i_id_rs2_addr,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic       i_ex_valid,
    input  logic [4:0] i_ex_rd_addr,
    input  logic       i_ex_mem_read,
    output logic       o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit = i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr);

    // A load into x0 never produces a value, so it cannot create a hazard.
    assign o_load_use = i_ex_valid && i_ex_mem_read &&
                        (i_ex_rd_addr != REG_X0) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush sequencer for the 5-stage RV32 pipeline. Resolves
// data-memory waits, multi-cycle EX operations, taken branches and load-use
// hazards, and counts stall cycles and flush events.
// Ports:
//   clk, reset_n                  : clock, asynchronous active-low reset
//   id_rs1_addr .. id_uses_rs2    : operand usage of the ID instruction
//   ex_valid, ex_rd_addr,
//   ex_mem_read, ex_branch_taken,
//   ex_mc_op                      : status of the EX instruction
//   mc_done                       : multi-cycle unit result pulse
//   dmem_req, dmem_ready          : MEM stage access / completion
//   mc_start                      : one-cycle start pulse to the MC unit
//   pc_stall, ifid_stall          : hold PC / IF/ID
//   ifid_flush, idex_flush        : squash IF/ID / ID/EX
//   ex_hold                       : hold ID/EX contents
//   exmem_bubble                  : inject a bubble into EX/MEM
//   pipe_freeze                   : hold every register (memory wait)
//   stall_cycles                  : wrapping count of pc_stall cycles
//   flush_count                   : saturating count of ifid_flush cycles
// All control outputs are combinational from the state and inputs.
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int FLUSH_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [4:0]         id_rs1_addr,
    input  logic [4:0]         id_rs2_addr,
    input  logic               id_uses_rs1,
    input  logic               id_uses_rs2,
    input  logic               ex_valid,
    input  logic [4:0]         ex_rd_addr,
    input  logic               ex_mem_read,
    input  logic               ex_branch_taken,
    input  logic               ex_mc_op,
    input  logic               mc_done,
    input  logic               dmem_req,
    input  logic               dmem_ready,
    output logic               mc_start,
    output logic               pc_stall,
    output logic               ifid_stall,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               ex_hold,
    output logic               exmem_bubble,
    output logic               pipe_freeze,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [FLUSH_W-1:0] flush_count
);

    ctrl_state_e        r_state;
    ctrl_state_e        w_next_state;
    logic               r_mc_done_seen;
    logic [CNT_W-1:0]   r_stall_cycles;
    logic [FLUSH_W-1:0] r_flush_count;

    logic w_mem_wait;
    logic w_load_use;
    logic w_mc_done_eff;

    hazard_detect u_hazard_detect (
        .i_id_rs1_addr (id_rs1_addr),
        .i_id_rs2_addr (id_rs2_addr),
        .i_id_uses_rs1 (id_uses_rs1),
        .i_id_uses_rs2 (id_uses_rs2),
        .i_ex_valid    (ex_valid),
        .i_ex_rd_addr  (ex_rd_addr),
        .i_ex_mem_read (ex_mem_read),
        .o_load_use    (w_load_use)
    );

    assign w_mem_wait = dmem_req && !dmem_ready;

    // In MC_DONE_WAIT the result has already been latched, so the live
    // mc_done input no longer matters there.
    assign w_mc_done_eff = ((r_state == MC_BUSY) && mc_done) ||
                           ((r_state == MC_DONE_WAIT) && r_mc_done_seen);

    always_comb begin
        w_next_state = r_state;
        mc_start     = 1'b0;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        ex_hold      = 1'b0;
        exmem_bubble = 1'b0;
        pipe_freeze  = 1'b0;

        if (w_mem_wait) begin
            // Memory wait overrides everything; a result arriving now must
            // be remembered until the freeze lifts.
            pipe_freeze = 1'b1;
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            ex_hold     = 1'b1;
            if (r_state == MC_BUSY && mc_done) begin
                w_next_state = MC_DONE_WAIT;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_valid && ex_mc_op) begin
                        mc_start     = 1'b1;
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        ex_hold      = 1'b1;
                        exmem_bubble = 1'b1;
                        w_next_state = MC_BUSY;
                    end else if (ex_branch_taken) begin
                        // Flush wins over load-use: the stalled ID instruction
                        // is on the wrong path anyway.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end
                end
                MC_BUSY, MC_DONE_WAIT: begin
                    if (w_mc_done_eff) begin
                        // All controls low: the EX instruction advances now.
                        w_next_state = RUN;
                    end else begin
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        ex_hold      = 1'b1;
                        exmem_bubble = 1'b1;
                    end
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end

        // Outputs go quiet as soon as reset is asserted, without waiting for
        // the state register to be cleared by the next event.
        if (!reset_n) begin
            mc_start     = 1'b0;
            pc_stall     = 1'b0;
            ifid_stall   = 1'b0;
            ifid_flush   = 1'b0;
            idex_flush   = 1'b0;
            ex_hold      = 1'b0;
            exmem_bubble = 1'b0;
            pipe_freeze  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= RUN;
            r_mc_done_seen <= 1'b0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state        <= w_next_state;
            r_mc_done_seen <= (w_next_state == MC_DONE_WAIT);
            if (pc_stall) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (ifid_flush && !(&r_flush_count)) begin
                r_flush_count <= r_flush_count + FLUSH_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed scenarios with literal expectations, followed by randomized
// traffic. A behavioural model (two flags: "multi-cycle op outstanding" and
// "result already received") predicts every output each cycle.
// Narrow counters make wrap and saturation reachable.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int CNT_W   = 8;
    localparam int FLUSH_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read;
    logic       ex_branch_taken, ex_mc_op, mc_done, dmem_req, dmem_ready;

    logic               mc_start, pc_stall, ifid_stall, ifid_flush;
    logic               idex_flush, ex_hold, exmem_bubble, pipe_freeze;
    logic [CNT_W-1:0]   stall_cycles;
    logic [FLUSH_W-1:0] flush_count;

    pipeline_ctrl #(.CNT_W(CNT_W), .FLUSH_W(FLUSH_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_valid        (ex_valid),
        .ex_rd_addr      (ex_rd_addr),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_mc_op        (ex_mc_op),
        .mc_done         (mc_done),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .mc_start        (mc_start),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .ex_hold         (ex_hold),
        .exmem_bubble    (exmem_bubble),
        .pipe_freeze     (pipe_freeze),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model
    bit m_busy;      // a multi-cycle op has been started and not retired
    bit m_have_res;  // its result arrived while memory was stalled
    int m_stall;
    int m_flush;
    bit e_start, e_pc, e_ifs, e_iff, e_idf, e_hold, e_bub, e_frz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit mem_wait();
        return dmem_req && !dmem_ready;
    endfunction

    function automatic bit load_use();
        return ex_valid && ex_mem_read && (ex_rd_addr != 5'd0) &&
               ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    endfunction

    task automatic model_outputs();
        {e_start, e_pc, e_ifs, e_iff, e_idf, e_hold, e_bub, e_frz} = '0;
        if (reset_n) begin
            if (mem_wait()) begin
                {e_frz, e_pc, e_ifs, e_hold} = 4'hF;
            end else if (m_busy) begin
                if (!(m_have_res || mc_done)) {e_pc, e_ifs, e_hold, e_bub} = 4'hF;
            end else if (ex_valid && ex_mc_op) begin
                {e_start, e_pc, e_ifs, e_hold, e_bub} = 5'h1F;
            end else if (ex_branch_taken) begin
                {e_iff, e_idf} = 2'b11;
            end else if (load_use()) begin
                {e_pc, e_ifs, e_idf} = 3'b111;
            end
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_have_res = 0; m_stall = 0; m_flush = 0;
    endtask

    // Compare every output against the model, away from the clock edge.
    task automatic settle();
        #2;
        model_outputs();
        chk("mc_start",     32'(mc_start),     32'(e_start));
        chk("pc_stall",     32'(pc_stall),     32'(e_pc));
        chk("ifid_stall",   32'(ifid_stall),   32'(e_ifs));
        chk("ifid_flush",   32'(ifid_flush),   32'(e_iff));
        chk("idex_flush",   32'(idex_flush),   32'(e_idf));
        chk("ex_hold",      32'(ex_hold),      32'(e_hold));
        chk("exmem_bubble", 32'(exmem_bubble), 32'(e_bub));
        chk("pipe_freeze",  32'(pipe_freeze),  32'(e_frz));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stall % (1 << CNT_W)));
        chk("flush_count",  32'(flush_count),  32'(m_flush));
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            if (e_pc) m_stall++;
            if (e_iff && m_flush < (1 << FLUSH_W) - 1) m_flush++;
            if (m_busy) begin
                if (m_have_res || mc_done) begin
                    if (mem_wait()) m_have_res = 1;
                    else begin m_busy = 0; m_have_res = 0; end
                end
            end else if (!mem_wait() && ex_valid && ex_mc_op) begin
                m_busy = 1;
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic clr();
        id_rs1_addr = 0; id_rs2_addr = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_valid = 0; ex_rd_addr = 0; ex_mem_read = 0; ex_branch_taken = 0;
        ex_mc_op = 0; mc_done = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        clr();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state, even with a memory wait presented.
        dmem_req = 1;
        settle();
        chk("reset_freeze", 32'(pipe_freeze), 32'd0);
        chk("reset_stall",  32'(stall_cycles), 32'd0);
        advance();
        clr();
        reset_n = 1'b1;

        // Load-use: one stall cycle.
        ex_valid = 1; ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 5; id_uses_rs1 = 1;
        settle();
        chk("lu_pc_stall",   32'(pc_stall),   32'd1);
        chk("lu_idex_flush", 32'(idex_flush), 32'd1);
        chk("lu_ex_hold",    32'(ex_hold),    32'd0);
        advance();
        // Same with rd=x0: no hazard.
        ex_rd_addr = 0; id_rs1_addr = 0;
        settle();
        chk("lu_x0_stall", 32'(pc_stall),     32'd0);
        chk("lu_cnt",      32'(stall_cycles), 32'd1);
        advance();

        // Branch beats load-use.
        ex_rd_addr = 5; id_rs1_addr = 5; ex_branch_taken = 1;
        settle();
        chk("br_ifid_flush", 32'(ifid_flush), 32'd1);
        chk("br_pc_stall",   32'(pc_stall),   32'd0);
        advance();
        clr();
        settle();
        chk("br_flush_cnt", 32'(flush_count), 32'd1);
        advance();

        // Multi-cycle op: start at T, done at T+5.
        ex_valid = 1; ex_mc_op = 1;
        settle();
        chk("mc_start_T", 32'(mc_start),     32'd1);
        chk("mc_bub_T",   32'(exmem_bubble), 32'd1);
        advance();
        for (int k = 1; k < 5; k++) begin
            settle();
            chk("mc_no_restart", 32'(mc_start), 32'd0);
            chk("mc_busy_stall", 32'(pc_stall), 32'd1);
            advance();
        end
        mc_done = 1;
        settle();
        chk("mc_done_stall", 32'(pc_stall),     32'd0);
        chk("mc_done_bub",   32'(exmem_bubble), 32'd0);
        advance();
        clr();
        settle();
        chk("mc_stall_cnt", 32'(stall_cycles), 32'd6);
        advance();

        // Memory wait with a pending branch: freeze 3 cycles, flush on 4th.
        dmem_req = 1; ex_branch_taken = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("mw_freeze",   32'(pipe_freeze), 32'd1);
            chk("mw_no_flush", 32'(ifid_flush),  32'd0);
            advance();
        end
        dmem_ready = 1;
        settle();
        chk("mw_flush_after", 32'(ifid_flush), 32'd1);
        advance();
        clr();
        settle();
        chk("mw_flush_cnt", 32'(flush_count),  32'd2);
        chk("mw_stall_cnt", 32'(stall_cycles), 32'd9);
        advance();

        // Result arrives during a freeze.
        ex_valid = 1; ex_mc_op = 1;
        step();
        dmem_req = 1; mc_done = 1;
        settle();
        chk("dw_freeze", 32'(pipe_freeze), 32'd1);
        advance();
        mc_done = 0;
        settle();
        chk("dw_held", 32'(pc_stall), 32'd1);
        advance();
        dmem_ready = 1;
        settle();
        chk("dw_release_stall", 32'(pc_stall), 32'd0);
        chk("dw_release_start", 32'(mc_start), 32'd0);
        advance();
        clr();
        settle();
        chk("dw_stall_cnt", 32'(stall_cycles), 32'd12);
        advance();

        // Asynchronous reset while MC_BUSY, then a fresh start.
        ex_valid = 1; ex_mc_op = 1;
        step();
        settle();
        reset_n = 1'b0;
        #1;
        chk("rst_pc_stall", 32'(pc_stall),     32'd0);
        chk("rst_bubble",   32'(exmem_bubble), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_flush_cnt", 32'(flush_count),  32'd0);
        model_reset();
        advance();
        reset_n = 1'b1;
        settle();
        chk("rst_fresh_start", 32'(mc_start), 32'd1);
        advance();
        mc_done = 1;
        step();
        clr();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            id_rs1_addr     = 5'($urandom_range(0, 3));
            id_rs2_addr     = 5'($urandom_range(0, 3));
            ex_rd_addr      = 5'($urandom_range(0, 3));
            id_uses_rs1     = 1'($urandom_range(0, 1));
            id_uses_rs2     = 1'($urandom_range(0, 1));
            ex_valid        = ($urandom_range(0, 7) != 0);
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 3) == 0);
            ex_mc_op        = ($urandom_range(0, 5) == 0);
            mc_done         = ($urandom_range(0, 5) == 0);
            dmem_req        = ($urandom_range(0, 2) == 0);
            dmem_ready      = 1'($urandom_range(0, 1));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
